// File: rtl/nanorv32_trace.sv
// Auxiliary package for the nanorv32 trace unit.
// The top-level module is in nanorv32_trace_rob.sv.
package nanorv32_trace_dummy_pkg;
  localparam int UNUSED_MARK = 0;
endpackage

// File: rtl/nanorv32_trace_pkg.sv
// Shared definitions for the nanorv32 retirement-trace reorder buffer.
// Kind codes, record field widths and a constant clog2 helper.
package nanorv32_trace_pkg;

  localparam logic [1:0] TRK_ALU   = 2'd0;
  localparam logic [1:0] TRK_LOAD  = 2'd1;
  localparam logic [1:0] TRK_STORE = 2'd2;

  localparam int KIND_W = 2;
  localparam int RD_W   = 5;
  localparam int DROP_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/nanorv32_trace_idxq.sv
// Index FIFO holding buffer slots of outstanding loads/stores.
// Ports: push/push_idx, pop, head_idx, count, empty, full, flush.
module nanorv32_trace_idxq
  import nanorv32_trace_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 3,
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_idx = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_idx;
  end

endmodule

// File: rtl/nanorv32_trace_rob.sv
// Retirement-trace reorder buffer: records retires in order, holds
// loads/stores until their bus transfer completes, drains on tr_*.
module nanorv32_trace_rob
  import nanorv32_trace_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 2,
  parameter int DATA_W  = 32,
  parameter int TS_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic [DATA_W-1:0] ret_instr,
  input  logic [KIND_W-1:0] ret_kind,
  input  logic              ret_wr_rd,
  input  logic [RD_W-1:0]   ret_rd,
  input  logic [DATA_W-1:0] ret_rd_wdata,
  input  logic [DATA_W-1:0] ret_addr,
  input  logic              dbus_done,
  input  logic [DATA_W-1:0] dbus_rdata,
  input  logic [DATA_W-1:0] dbus_wdata,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [DATA_W-1:0] tr_pc,
  output logic [DATA_W-1:0] tr_instr,
  output logic [DATA_W-1:0] tr_data,
  output logic [DATA_W-1:0] tr_addr,
  output logic [KIND_W-1:0] tr_kind,
  output logic              tr_wr_rd,
  output logic [RD_W-1:0]   tr_rd,
  output logic [TS_W-1:0]   tr_ts,
  output logic              full,
  output logic              overflow,
  output logic              proto_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW  = clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int QAW = (MAX_OUT > 1) ? clog2(MAX_OUT) : 1;
  localparam int QCW = QAW + 1;

  logic [DATA_W-1:0] e_pc    [DEPTH];
  logic [DATA_W-1:0] e_instr [DEPTH];
  logic [DATA_W-1:0] e_data  [DEPTH];
  logic [DATA_W-1:0] e_addr  [DEPTH];
  logic [KIND_W-1:0] e_kind  [DEPTH];
  logic              e_wr_rd [DEPTH];
  logic [RD_W-1:0]   e_rd    [DEPTH];
  logic [TS_W-1:0]   e_ts    [DEPTH];
  logic              e_done  [DEPTH];

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [TS_W-1:0] ts;

  logic           is_mem;
  logic           alloc;
  logic           drop;
  logic           cmpl;
  logic           bad;
  logic           pop;
  logic [AW-1:0]  pend_head;
  logic [QCW-1:0] pend_cnt;
  logic           pend_empty;
  logic           pend_full;

  assign is_mem = (ret_kind == TRK_LOAD) ||
                  (ret_kind == TRK_STORE);

  // A full pending queue implies a memory entry is resident.
  assign full = (count == CW'(DEPTH)) ||
                (pend_cnt == QCW'(MAX_OUT));

  assign alloc = ret_valid && !full && !flush;
  assign drop  = ret_valid && full && !flush;
  assign cmpl  = dbus_done && !pend_empty && !flush;
  assign bad   = dbus_done && pend_empty && !flush;
  assign pop   = tr_valid && tr_ready && !flush;

  nanorv32_trace_idxq #(
    .DEPTH (MAX_OUT),
    .IDX_W (AW)
  ) u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (alloc && is_mem && !pend_full),
    .push_idx (wr_ptr),
    .pop      (cmpl),
    .head_idx (pend_head),
    .count    (pend_cnt),
    .empty    (pend_empty),
    .full     (pend_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ts        <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      drop_cnt  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ts        <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (alloc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (alloc && !pop)
        count <= count + CW'(1);
      else if (pop && !alloc)
        count <= count - CW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + DROP_W'(1);
      end
      if (bad) proto_err <= 1'b1;
    end
  end

  // Payload needs no reset: count gates every read.
  // A completion never targets wr_ptr (that slot is free).
  always_ff @(posedge clk) begin
    if (alloc) begin
      e_pc[wr_ptr]    <= ret_pc;
      e_instr[wr_ptr] <= ret_instr;
      e_addr[wr_ptr]  <= ret_addr;
      e_wr_rd[wr_ptr] <= ret_wr_rd;
      e_rd[wr_ptr]    <= ret_rd;
      e_ts[wr_ptr]    <= ts;
      e_data[wr_ptr]  <= ret_rd_wdata;
      e_kind[wr_ptr]  <= is_mem ? ret_kind : TRK_ALU;
      e_done[wr_ptr]  <= !is_mem;
    end
    if (cmpl) begin
      e_done[pend_head] <= 1'b1;
      e_data[pend_head] <=
        (e_kind[pend_head] == TRK_LOAD) ? dbus_rdata
                                        : dbus_wdata;
    end
  end

  assign tr_valid = (count != '0) && e_done[rd_ptr];
  assign tr_pc    = e_pc[rd_ptr];
  assign tr_instr = e_instr[rd_ptr];
  assign tr_data  = e_data[rd_ptr];
  assign tr_addr  = e_addr[rd_ptr];
  assign tr_kind  = e_kind[rd_ptr];
  assign tr_wr_rd = e_wr_rd[rd_ptr];
  assign tr_rd    = e_rd[rd_ptr];
  assign tr_ts    = e_ts[rd_ptr];

endmodule

// File: tb/tb_nanorv32_trace_rob.sv
// Scoreboard bench for nanorv32_trace_rob: queue-based model of
// the program-order record stream, compared every negedge.
module tb_nanorv32_trace_rob;

  localparam int DEPTH   = 8;
  localparam int MAX_OUT = 2;

  logic        clk = 0;
  logic        rst_n, flush;
  logic        ret_valid, ret_wr_rd;
  logic [31:0] ret_pc, ret_instr, ret_rd_wdata, ret_addr;
  logic [1:0]  ret_kind;
  logic [4:0]  ret_rd;
  logic        dbus_done;
  logic [31:0] dbus_rdata, dbus_wdata;
  logic        tr_valid, tr_ready, tr_wr_rd;
  logic [31:0] tr_pc, tr_instr, tr_data, tr_addr, tr_ts;
  logic [1:0]  tr_kind;
  logic [4:0]  tr_rd;
  logic        full, overflow, proto_err;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  nanorv32_trace_rob #(
    .DEPTH(DEPTH), .MAX_OUT(MAX_OUT),
    .DATA_W(32), .TS_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_instr(ret_instr), .ret_kind(ret_kind),
    .ret_wr_rd(ret_wr_rd), .ret_rd(ret_rd),
    .ret_rd_wdata(ret_rd_wdata), .ret_addr(ret_addr),
    .dbus_done(dbus_done), .dbus_rdata(dbus_rdata),
    .dbus_wdata(dbus_wdata), .tr_valid(tr_valid),
    .tr_ready(tr_ready), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .tr_data(tr_data),
    .tr_addr(tr_addr), .tr_kind(tr_kind),
    .tr_wr_rd(tr_wr_rd), .tr_rd(tr_rd), .tr_ts(tr_ts),
    .full(full), .overflow(overflow),
    .proto_err(proto_err), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int          seq;
    logic [31:0] pc, instr, data, addr, ts;
    logic [1:0]  kind;
    logic        wr_rd;
    logic [4:0]  rd;
    bit          done;
  } rec_t;

  rec_t        exp_q[$];
  int          pend_q[$];
  int          seq_n = 0;
  bit          m_ovf, m_perr;
  int          m_drop;
  logic [31:0] m_ts;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic void chk(string n, logic [63:0] a,
                              logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               n, a, e, $time);
    end
  endfunction

  // Reference model: list of records in program order plus a FIFO
  // of the sequence numbers still waiting for bus completion.
  always @(posedge clk or negedge rst_n) begin
    bit   mfull, do_pop;
    rec_t r;
    int   s;
    if (!rst_n || flush) begin
      exp_q.delete();
      pend_q.delete();
      m_ovf = 0; m_perr = 0; m_drop = 0; m_ts = 0;
    end else begin
      mfull = (exp_q.size() == DEPTH) ||
              (pend_q.size() == MAX_OUT);
      do_pop = exp_q.size() > 0 && exp_q[0].done &&
               tr_ready;
      if (dbus_done) begin
        if (pend_q.size() > 0) begin
          s = pend_q.pop_front();
          foreach (exp_q[i])
            if (exp_q[i].seq == s) begin
              exp_q[i].done = 1;
              exp_q[i].data = (exp_q[i].kind == 2'd1)
                              ? dbus_rdata : dbus_wdata;
            end
        end else m_perr = 1;
      end
      if (do_pop) void'(exp_q.pop_front());
      if (ret_valid) begin
        if (mfull) begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end else begin
          r.seq   = seq_n++;
          r.pc    = ret_pc;
          r.instr = ret_instr;
          r.addr  = ret_addr;
          r.wr_rd = ret_wr_rd;
          r.rd    = ret_rd;
          r.ts    = m_ts;
          r.kind  = (ret_kind == 2'd3) ? 2'd0 : ret_kind;
          r.done  = (r.kind == 2'd0);
          r.data  = r.done ? ret_rd_wdata : 'x;
          exp_q.push_back(r);
          if (!r.done) pend_q.push_back(r.seq);
        end
      end
      m_ts++;
    end
  end

  // Monitor: whatever the DUT presents is compared to the model head.
  always @(negedge clk) begin
    bit ev;
    if (rst_n) begin
      ev = exp_q.size() > 0 && exp_q[0].done;
      chk("tr_valid", 64'(tr_valid), 64'(ev));
      chk("full", 64'(full),
          64'((exp_q.size() == DEPTH) ||
              (pend_q.size() == MAX_OUT)));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (ev) begin
        chk("tr_pc", 64'(tr_pc), 64'(exp_q[0].pc));
        chk("tr_instr", 64'(tr_instr), 64'(exp_q[0].instr));
        chk("tr_data", 64'(tr_data), 64'(exp_q[0].data));
        chk("tr_addr", 64'(tr_addr), 64'(exp_q[0].addr));
        chk("tr_kind", 64'(tr_kind), 64'(exp_q[0].kind));
        chk("tr_wr_rd", 64'(tr_wr_rd), 64'(exp_q[0].wr_rd));
        chk("tr_rd", 64'(tr_rd), 64'(exp_q[0].rd));
        chk("tr_ts", 64'(tr_ts), 64'(exp_q[0].ts));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [1:0] k,
                        input logic [31:0] pc,
                        input logic [31:0] wd,
                        input logic [31:0] ad);
    ret_valid    = 1;
    ret_kind     = k;
    ret_pc       = pc;
    ret_rd_wdata = wd;
    ret_addr     = ad;
    ret_instr    = $urandom;
    ret_rd       = 5'($urandom);
    ret_wr_rd    = 1'($urandom);
    step();
    ret_valid = 0;
  endtask

  task automatic bus(input logic [31:0] rd,
                     input logic [31:0] wd);
    dbus_done  = 1;
    dbus_rdata = rd;
    dbus_wdata = wd;
    step();
    dbus_done = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  initial begin
    rst_n = 0; flush = 0; ret_valid = 0; ret_wr_rd = 0;
    ret_pc = 0; ret_instr = 0; ret_rd_wdata = 0;
    ret_addr = 0; ret_kind = 0; ret_rd = 0;
    dbus_done = 0; dbus_rdata = 0; dbus_wdata = 0;
    tr_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst tr_valid", 64'(tr_valid), 64'(0));
    chk("rst full", 64'(full), 64'(0));
    step();

    // In-order ALU stream.
    retire(2'd0, 32'h100, 32'h11, 32'h0);
    retire(2'd0, 32'h104, 32'h22, 32'h0);
    retire(2'd0, 32'h108, 32'h33, 32'h0);
    repeat (3) step();

    // Load blocks two younger ALU records.
    retire(2'd1, 32'h200, 32'h0, 32'h8000_0010);
    retire(2'd0, 32'h204, 32'h44, 32'h0);
    retire(2'd0, 32'h208, 32'h55, 32'h0);
    step();
    chk("ld blocks", 64'(tr_valid), 64'(0));
    bus(32'hCAFF_E000, 32'h0);
    repeat (5) step();

    // Pending queue full: third memory op dropped.
    retire(2'd1, 32'h300, 32'h0, 32'h10);
    retire(2'd2, 32'h304, 32'h0, 32'h14);
    retire(2'd1, 32'h308, 32'h0, 32'h18);
    chk("ovf set", 64'(overflow), 64'(1));
    chk("drop 1", 64'(drop_cnt), 64'(1));
    bus(32'h1234_5678, 32'h0);
    bus(32'h0, 32'hDEAD_D000);
    repeat (4) step();
    do_flush();

    // Backpressure: 10 retires into 8 slots.
    tr_ready = 0;
    for (int i = 0; i < 10; i++)
      retire(2'd0, 32'h400 + 32'(4 * i), 32'(i), 32'h0);
    chk("drop 2", 64'(drop_cnt), 64'(2));
    chk("full 8", 64'(full), 64'(1));
    repeat (3) step();
    tr_ready = 1;
    repeat (10) step();
    chk("drained", 64'(tr_valid), 64'(0));

    // Completion with nothing outstanding.
    do_flush();
    bus(32'h0, 32'h0);
    chk("perr set", 64'(proto_err), 64'(1));
    do_flush();
    chk("perr clr", 64'(proto_err), 64'(0));
    chk("drop clr", 64'(drop_cnt), 64'(0));

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      ret_valid    = 1'($urandom % 2);
      ret_kind     = 2'($urandom);
      ret_pc       = $urandom;
      ret_instr    = $urandom;
      ret_rd_wdata = $urandom;
      ret_addr     = $urandom;
      ret_rd       = 5'($urandom);
      ret_wr_rd    = 1'($urandom);
      dbus_rdata   = $urandom;
      dbus_wdata   = $urandom;
      dbus_done    = (pend_q.size() > 0)
                     ? ($urandom % 3 == 0)
                     : ($urandom % 64 == 0);
      tr_ready     = ($urandom % 4 != 0);
      flush        = ($urandom % 256 == 0);
      step();
    end
    ret_valid = 0; dbus_done = 0; flush = 0;

    // Asynchronous reset with memory ops outstanding.
    tr_ready = 0;
    retire(2'd1, 32'h500, 32'h0, 32'h20);
    retire(2'd2, 32'h504, 32'h0, 32'h24);
    retire(2'd0, 32'h508, 32'h66, 32'h0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst valid", 64'(tr_valid), 64'(0));
    chk("arst full", 64'(full), 64'(0));
    chk("arst ovf", 64'(overflow), 64'(0));
    chk("arst perr", 64'(proto_err), 64'(0));
    chk("arst drop", 64'(drop_cnt), 64'(0));
    #2 rst_n = 1;
    tr_ready = 1;
    retire(2'd0, 32'h600, 32'h77, 32'h0);
    chk("restart ts", 64'(tr_ts), 64'(0));
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
